// File: rtl/decode_buffer.sv
// Instruction queue plus head decoder between fetch and execute, with load-use interlock,
// synchronous flush and sticky halt. Define DECODE_BUF_STATS_EN to add bubble/full counters.
module decode_buffer #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ins_valid,
  input  logic [WORD_W-1:0] ins,
  input  logic [WORD_W-1:0] ins_pc,
  output logic              ins_ready,
  input  logic              flush,
  input  logic              dec_ready,
  output logic              dec_valid,
  output logic [WORD_W-1:0] dec_pc,
  output logic [REG_W-1:0]  rsel1,
  output logic [REG_W-1:0]  rsel2,
  output logic [REG_W-1:0]  wsel,
  output logic              wen,
  output logic [WORD_W-1:0] imm,
  output logic              is_load,
  output logic              is_store,
  output logic              halt,
`ifdef DECODE_BUF_STATS_EN
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       full_cnt,
`endif
  output logic              halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] mem_ins_q [DEPTH];
  logic [WORD_W-1:0] mem_ins_d [DEPTH];
  logic [WORD_W-1:0] mem_pc_q  [DEPTH];
  logic [WORD_W-1:0] mem_pc_d  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pend_valid_q, pend_valid_d;
  logic [REG_W-1:0]  pend_reg_q, pend_reg_d;
  logic              halted_q, halted_d;

  logic [WORD_W-1:0] head_ins, head_pc;
  logic [5:0]        op;
  logic              not_empty, stall, enq, deq;

  assign head_ins  = mem_ins_q[rd_ptr_q];
  assign head_pc   = mem_pc_q[rd_ptr_q];
  assign op        = head_ins[31:26];
  assign not_empty = (count_q != '0);

  // Head decode; every field reads zero while the buffer is empty.
  always_comb begin
    dec_pc   = '0;
    rsel1    = '0;
    rsel2    = '0;
    wsel     = '0;
    wen      = 1'b0;
    imm      = '0;
    is_load  = 1'b0;
    is_store = 1'b0;
    halt     = 1'b0;
    if (not_empty) begin
      dec_pc = head_pc;
      rsel1  = REG_W'(head_ins[25:21]);
      rsel2  = REG_W'(head_ins[20:16]);
      if (op == 6'b000000) begin
        wsel = REG_W'(head_ins[15:11]);
        wen  = (head_ins[5:0] != 6'b001000);
      end else if (op[5:3] == 3'b001 || op == 6'b100011) begin
        wsel = REG_W'(head_ins[20:16]);
        wen  = 1'b1;
      end else if (op == 6'b000011) begin
        wsel = REG_W'(31);
        wen  = 1'b1;
      end
      if (wsel == '0) wen = 1'b0;
      if (op == 6'b001100 || op == 6'b001101 || op == 6'b001110)
        imm = WORD_W'(head_ins[15:0]);
      else if (op == 6'b001111)
        imm = WORD_W'({head_ins[15:0], 16'h0000});
      else
        imm = WORD_W'($signed(head_ins[15:0]));
      is_load  = (op == 6'b100011);
      is_store = (op == 6'b101011);
      halt     = (op == 6'b111111);
    end
  end

  // pend_reg_q is only ever nonzero while pend_valid_q is set, so $0 cannot stall.
  assign stall     = pend_valid_q && (rsel1 == pend_reg_q || rsel2 == pend_reg_q);
  assign dec_valid = not_empty & ~halted_q & ~stall;
  assign ins_ready = (count_q < CNT_W'(DEPTH)) & ~halted_q;
  assign halted    = halted_q;
  assign enq       = ins_valid & ins_ready;
  assign deq       = dec_valid & dec_ready;

  always_comb begin
    mem_ins_d    = mem_ins_q;
    mem_pc_d     = mem_pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pend_valid_d = 1'b0;
    pend_reg_d   = '0;
    halted_d     = halted_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        mem_ins_d[wr_ptr_q] = ins;
        mem_pc_d[wr_ptr_q]  = ins_pc;
        wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (is_load && wsel != '0) begin
          pend_valid_d = 1'b1;
          pend_reg_d   = wsel;
        end
        if (halt) halted_d = 1'b1;
      end
      if (enq && !deq)      count_d = count_q + 1'b1;
      else if (!enq && deq) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_ins_q[i] <= '0;
        mem_pc_q[i]  <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_reg_q   <= '0;
      halted_q     <= 1'b0;
    end else begin
      mem_ins_q    <= mem_ins_d;
      mem_pc_q     <= mem_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pend_valid_q <= pend_valid_d;
      pend_reg_q   <= pend_reg_d;
      halted_q     <= halted_d;
    end
  end

`ifdef DECODE_BUF_STATS_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d, full_cnt_q, full_cnt_d;

  // Both counters saturate at all-ones.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    full_cnt_d   = full_cnt_q;
    if (not_empty && !halted_q && stall && !(&bubble_cnt_q))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (ins_valid && count_q == CNT_W'(DEPTH) && !(&full_cnt_q))
      full_cnt_d = full_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bubble_cnt_q <= '0;
      full_cnt_q   <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      full_cnt_q   <= full_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign full_cnt   = full_cnt_q;
`endif

endmodule

// File: doc/decode_buffer.md
Name: decode_buffer

Overview:
- Parametrised instruction queue plus decoder between fetch and execute in the pipelined MIPS core. It is the successor to the combinational decode unit.
- Fetched words and PCs are buffered in a DEPTH-entry FIFO, and the head entry is decoded into register selects, write enable, immediate and memory-op flags.
- Valid/ready handshakes on both sides. Adds a one-bubble load-use interlock, a synchronous flush and sticky halt.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- WORD_W, 32, instruction/PC/immediate width; ≥32.
- REG_W, 5, register-select width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ins_valid  in  1  fetch presents an instruction.
- ins  in  WORD_W  instruction word.
- ins_pc  in  WORD_W  PC of ins.
- ins_ready  out  1  buffer accepts this cycle.
- flush  in  1  discard all buffered entries (branch/jump redirect).
- dec_ready  in  1  execute accepts the head.
- dec_valid  out  1  head decode valid.
- dec_pc  out  WORD_W  PC of head.
- rsel1  out  REG_W  ins[25:21].
- rsel2  out  REG_W  ins[20:16].
- wsel  out  REG_W  destination register.
- wen  out  1  register-file write.
- imm  out  WORD_W  extended immediate.
- is_load  out  1  LW.
- is_store  out  1  SW.
- halt  out  1  head is HALT.
- halted  out  1  sticky halt status.

Behaviour:
- **Reset** (async, nRST=0):
  - pointers, count, hazard tracker and halted cleared; storage zeroed.
  - ins_ready=1, dec_valid=0, halted=0.
  - all decoded fields 0.
- **FIFO:**
  - count width $clog2(DEPTH+1); read/write pointers wrap modulo DEPTH.
  - enq = ins_valid & ins_ready; ins_ready = (count<DEPTH) & ~halted.
  - No full-bypass: when full, ins_ready=0 even if the head dequeues that cycle.
  - deq = dec_valid & dec_ready. Simultaneous enq and deq leave count unchanged.
- **Latency:** an instruction enqueued into an empty buffer at edge N is presented at dec_* after edge N (1 cycle). Head decode is combinational from storage.
- **Empty:** dec_valid=0; all decoded fields 0.
- **Decode** of head, op=ins[31:26]:
  - R-type (000000): wsel=ins[15:11]; wen=1 except JR (funct 001000), where wen=0.
  - I-type ALU (001xxx) and LW (100011): wsel=ins[20:16], wen=1.
  - JAL (000011): wsel=31, wen=1.
  - All other opcodes: wen=0, wsel=0.
  - wen is forced 0 when wsel=0.
  - imm:
    - ANDI/ORI/XORI: zero-extend.
    - LUI: {ins[15:0],16'b0} zero-extended to WORD_W.
    - else: sign-extend ins[15:0].
  - is_load = LW; is_store = SW (101011); halt = op 111111.
- **Load-use interlock:**
  - On deq of a load with nonzero wsel, record that wsel as pending for exactly the next cycle.
  - In that next cycle, if the head's rsel1 or rsel2 equals the pending wsel, force dec_valid=0 for one cycle (bubble); no deq occurs.
  - The pending record is cleared after that cycle regardless.
  - A register number of 0 never stalls.
- **Halt:**
  - On deq of a HALT entry, halted←1 at that edge.
  - Thereafter ins_ready=0 and dec_valid=0; entries stay frozen.
  - halted is cleared only by nRST.
- **Flush** (synchronous):
  - At the edge, count←0, pointers←0 and the pending hazard is cleared.
  - Same-cycle enq and deq are discarded; any deq that cycle is not counted as accepted.
  - halted is unaffected.
- **Reset mid-operation:** immediate asynchronous return to reset values; buffered contents are lost.

Optional Feature:
- Macro: DECODE_BUF_STATS_EN.
- Defined, two extra outputs, both 32 bits, saturating at all-ones and cleared by nRST:
  - bubble_cnt: increments on each interlock bubble cycle.
  - full_cnt: increments each cycle with ins_valid=1 and count=DEPTH.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset then enqueue ADDI $2,$1,-1 (0x2022FFFF) at PC 0x0:
  - after 1 cycle: dec_valid=1, rsel1=1, wsel=2, wen=1, imm=0xFFFFFFFF.
  - ORI $3,$0,0x8000: imm=0x00008000.
- dec_ready=0, enqueue 5 words with DEPTH=4:
  - ins_ready=0 after the 4th; the 5th is held.
  - Release dec_ready: outputs appear in order PC 0,4,8,C, then the 5th enters.
- LW $4,0($1) dequeued, then head ADD $5,$4,$6:
  - exactly one dec_valid=0 cycle, then ADD presented.
  - Same case with LW $0 as the load: no bubble.
- Fill 3 entries, assert flush with dec_ready=1 and ins_valid=1 in the same cycle:
  - next cycle count=0, dec_valid=0, no deq accepted.
- HALT (0xFFFFFFFF) dequeued:
  - halted=1 forever, ins_ready=0, dec_valid=0.
  - flush leaves halted=1; nRST pulse clears it.
- Assert nRST low mid-stream with 2 entries queued:
  - outputs zero immediately, without waiting for a CLK edge.
  - Resume: the first new word is delivered correctly.
